// File: rtl/maclyr_seq_if.sv
// rtl/maclyr_seq_if.sv - handshake bundle between the MAC neuron and its buffers
interface maclyr_seq_if #(
    parameter int W      = 16,
    parameter int N_TAPS = 9
);
    localparam int CNT_W = $clog2(N_TAPS + 1);

    logic             start;
    logic [W-1:0]     bias;
    logic             relu_en;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    logic [W-1:0]     in_weight;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_data;
    logic             busy;
    logic [CNT_W-1:0] tap_cnt;

    modport master (
        output start, bias, relu_en, in_valid, in_data, in_weight, out_ready,
        input  in_ready, out_valid, out_data, busy, tap_cnt
    );

    modport slave (
        input  start, bias, relu_en, in_valid, in_data, in_weight, out_ready,
        output in_ready, out_valid, out_data, busy, tap_cnt
    );
endinterface

// File: rtl/maclyr_seq.sv
// rtl/maclyr_seq.sv - time-multiplexed fixed-point MAC neuron with rescale, saturation and ReLU
module maclyr_seq #(
    parameter int W      = 16,
    parameter int FRAC   = 8,
    parameter int N_TAPS = 9,
    parameter int SAT    = 1
) (
    input logic         clk,
    input logic         rst_n,
    maclyr_seq_if.slave bus
);
    localparam int CNT_W = $clog2(N_TAPS + 1);
    localparam int ACC_W = 2 * W + $clog2(N_TAPS) + 2;

    localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-W+1){1'b1}}, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

    state_t                  state;
    state_t                  state_nx;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] bias_ext;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] shifted;
    logic signed [2*W-1:0]   prod;
    logic [CNT_W-1:0]        cnt;
    logic                    relu_q;
    logic [W-1:0]            out_q;
    logic [W-1:0]            clip;
    logic [W-1:0]            res;
    logic                    accept;
    logic                    last;
    logic                    load;

    // Full-precision datapath: product and bias are sign-extended, never truncated before the sum.
    always_comb begin
        prod     = $signed(bus.in_data) * $signed(bus.in_weight);
        prod_ext = {{(ACC_W-2*W){prod[2*W-1]}}, prod};
        bias_ext = {{(ACC_W-W){bus.bias[W-1]}}, bus.bias} <<< FRAC;
        sum      = acc + prod_ext;
        shifted  = sum >>> FRAC;
    end

    always_comb begin
        clip = shifted[W-1:0];
        if (SAT != 0) begin
            if (shifted > MAX_V) begin
                clip = {1'b0, {(W-1){1'b1}}};
            end else if (shifted < MIN_V) begin
                clip = {1'b1, {(W-1){1'b0}}};
            end
        end
        res = (relu_q && clip[W-1]) ? '0 : clip;
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        last     = (cnt == CNT_W'(N_TAPS - 1));
        load     = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    load     = 1'b1;
                    state_nx = ACC;
                end
            end
            ACC: begin
                accept = bus.in_valid;
                if (bus.in_valid && last) begin
                    state_nx = OUT;
                end
            end
            OUT: begin
                // A start coinciding with the result handshake chains the next neuron without a bubble.
                if (bus.out_ready) begin
                    load     = bus.start;
                    state_nx = bus.start ? ACC : IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            cnt    <= '0;
            relu_q <= 1'b0;
            out_q  <= '0;
        end else if (load) begin
            acc    <= bias_ext;
            cnt    <= '0;
            relu_q <= bus.relu_en;
        end else if (accept) begin
            acc <= sum;
            cnt <= cnt + CNT_W'(1);
            if (last) begin
                out_q <= res;
            end
        end
    end

    assign bus.in_ready  = (state == ACC);
    assign bus.out_valid = (state == OUT);
    assign bus.busy      = (state != IDLE);
    assign bus.out_data  = out_q;
    assign bus.tap_cnt   = cnt;
endmodule

// File: tb/tb_maclyr_seq.sv
// tb/tb_maclyr_seq.sv - self-checking bench for maclyr_seq (saturating and wrapping builds in lockstep)
module tb_maclyr_seq;
    localparam int W      = 16;
    localparam int FRAC   = 8;
    localparam int N_TAPS = 9;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   passed = 0;
    int   total = 0;

    logic signed [W-1:0] d [N_TAPS];
    logic signed [W-1:0] w [N_TAPS];
    logic [W-1:0]        cur_bias;
    logic                cur_relu;

    maclyr_seq_if #(.W(W), .N_TAPS(N_TAPS)) ifs ();
    maclyr_seq_if #(.W(W), .N_TAPS(N_TAPS)) ifw ();

    assign ifw.start     = ifs.start;
    assign ifw.bias      = ifs.bias;
    assign ifw.relu_en   = ifs.relu_en;
    assign ifw.in_valid  = ifs.in_valid;
    assign ifw.in_data   = ifs.in_data;
    assign ifw.in_weight = ifs.in_weight;
    assign ifw.out_ready = ifs.out_ready;

    maclyr_seq #(.W(W), .FRAC(FRAC), .N_TAPS(N_TAPS), .SAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .bus(ifs)
    );
    maclyr_seq #(.W(W), .FRAC(FRAC), .N_TAPS(N_TAPS), .SAT(0)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .bus(ifw)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Reference: real-valued neuron evaluated with 64-bit integers, then floor-scaled and clamped.
    function automatic logic [W-1:0] model(input logic [W-1:0] b, input logic r, input bit sat);
        longint acc;
        longint q;
        logic [W-1:0] y;
        acc = longint'($signed(b)) * 256;
        for (int k = 0; k < N_TAPS; k++) acc += longint'(d[k]) * longint'(w[k]);
        q = acc >>> FRAC;
        if (sat && q > 32767) y = 16'h7FFF;
        else if (sat && q < -32768) y = 16'h8000;
        else y = q[15:0];
        if (r && y[15]) y = '0;
        return y;
    endfunction

    task automatic set_const(input logic [W-1:0] dv, input logic [W-1:0] wv);
        for (int k = 0; k < N_TAPS; k++) begin
            d[k] = dv;
            w[k] = wv;
        end
    endtask

    task automatic set_rand(input bit full);
        for (int k = 0; k < N_TAPS; k++) begin
            d[k] = full ? W'($urandom) : W'($urandom_range(1023)) - 16'd512;
            w[k] = full ? W'($urandom) : W'($urandom_range(1023)) - 16'd512;
        end
    endtask

    task automatic do_start(input logic [W-1:0] b, input logic r);
        ifs.start = 1'b1;
        ifs.bias = b;
        ifs.relu_en = r;
        cur_bias = b;
        cur_relu = r;
        @(negedge clk);
        ifs.start = 1'b0;
        check("start_in_ready", ifs.in_ready, 1);
        check("start_tap_cnt", ifs.tap_cnt, 0);
    endtask

    task automatic feed(input int prob, input int lim, input bit spur);
        int i = 0;
        int cyc = 0;
        bit v;
        while (i < lim && cyc < 500) begin
            if (ifs.in_ready !== 1'b1 || ifs.tap_cnt !== 4'(i) || ifs.out_valid !== 1'b0)
                check("acc_state", {ifs.in_ready, ifs.out_valid, 4'(ifs.tap_cnt)}, {2'b10, 4'(i)});
            v = ($urandom_range(99) < prob);
            ifs.in_valid = v;
            ifs.in_data = d[i];
            ifs.in_weight = w[i];
            ifs.start = spur && (i == 4);
            if (spur && i == 4) begin
                ifs.bias = 16'h7777;
                ifs.relu_en = ~cur_relu;
            end
            @(negedge clk);
            if (v) i++;
            cyc++;
        end
        ifs.in_valid = 1'b0;
        ifs.start = 1'b0;
        if (i < lim) check("feed_timeout", i, lim);
        if (lim == N_TAPS) begin
            check("out_latency", ifs.out_valid, 1);
            check("out_in_ready", ifs.in_ready, 0);
            check("out_tap_cnt", ifs.tap_cnt, N_TAPS);
            check("result_sat", ifs.out_data, model(cur_bias, cur_relu, 1));
            check("result_wrap", ifw.out_data, model(cur_bias, cur_relu, 0));
        end
    endtask

    task automatic finish_out(input int stall, input bit spur, input bit b2b,
                              input logic [W-1:0] nb, input logic nr);
        logic [W-1:0] hs;
        logic [W-1:0] hw;
        hs = ifs.out_data;
        hw = ifw.out_data;
        for (int k = 0; k < stall; k++) begin
            ifs.out_ready = 1'b0;
            ifs.start = spur && (k == 1);
            ifs.bias = 16'h1234;
            @(negedge clk);
            ifs.start = 1'b0;
            check("stall_valid", ifs.out_valid, 1);
            check("stall_in_ready", ifs.in_ready, 0);
            check("stall_data_sat", ifs.out_data, hs);
            check("stall_data_wrap", ifw.out_data, hw);
        end
        ifs.out_ready = 1'b1;
        ifs.start = b2b;
        ifs.bias = nb;
        ifs.relu_en = nr;
        if (b2b) begin
            cur_bias = nb;
            cur_relu = nr;
        end
        @(negedge clk);
        ifs.out_ready = 1'b0;
        ifs.start = 1'b0;
        check("post_out_valid", ifs.out_valid, 0);
        if (b2b) begin
            check("b2b_in_ready", ifs.in_ready, 1);
            check("b2b_tap_cnt", ifs.tap_cnt, 0);
        end else begin
            check("post_busy", ifs.busy, 0);
        end
    endtask

    initial begin
        ifs.start = 0;
        ifs.bias = '0;
        ifs.relu_en = 0;
        ifs.in_valid = 0;
        ifs.in_data = '0;
        ifs.in_weight = '0;
        ifs.out_ready = 0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", ifs.in_ready, 0);
        check("rst_out_valid", ifs.out_valid, 0);
        check("rst_busy", ifs.busy, 0);
        check("rst_out_data", ifs.out_data, 0);
        check("rst_tap_cnt", ifs.tap_cnt, 0);
        rst_n = 1'b1;
        @(negedge clk);

        set_const(16'h0100, 16'h0100);
        do_start(16'h0080, 0);
        feed(100, N_TAPS, 0);
        check("basic_const", ifs.out_data, 16'h0980);
        finish_out(0, 0, 0, '0, 0);

        set_const(16'hFF00, 16'h0200);
        do_start(16'h0000, 0);
        feed(100, N_TAPS, 0);
        check("neg_const", ifs.out_data, 16'hEE00);
        finish_out(0, 0, 0, '0, 0);
        do_start(16'h0000, 1);
        feed(100, N_TAPS, 0);
        check("relu_const", ifs.out_data, 16'h0000);
        finish_out(0, 0, 0, '0, 0);

        set_const(16'h7FFF, 16'h7FFF);
        do_start(16'h0000, 0);
        feed(100, N_TAPS, 0);
        check("sat_pos_const", ifs.out_data, 16'h7FFF);
        check("wrap_pos_const", ifw.out_data, 16'hF700);
        finish_out(0, 0, 0, '0, 0);
        set_const(16'h8000, 16'h7FFF);
        do_start(16'h0000, 0);
        feed(100, N_TAPS, 0);
        check("sat_neg_const", ifs.out_data, 16'h8000);
        finish_out(0, 0, 0, '0, 0);

        set_rand(0);
        do_start(W'($urandom), 1'($urandom));
        for (int n = 0; n < 6; n++) begin
            feed(50, N_TAPS, 0);
            set_rand(n[0]);
            finish_out(5, 0, n < 5, W'($urandom), 1'($urandom));
        end

        set_rand(0);
        do_start(16'h0040, 0);
        feed(70, N_TAPS, 1);
        finish_out(4, 1, 0, '0, 0);

        set_const(16'h0100, 16'h0100);
        do_start(16'h0080, 0);
        feed(100, 4, 0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", ifs.busy, 0);
        check("midrst_in_ready", ifs.in_ready, 0);
        check("midrst_out_valid", ifs.out_valid, 0);
        check("midrst_tap_cnt", ifs.tap_cnt, 0);
        check("midrst_out_data", ifs.out_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("midrst_no_valid", ifs.out_valid, 0);
        end
        do_start(16'h0080, 0);
        feed(100, N_TAPS, 0);
        check("midrst_new_const", ifs.out_data, 16'h0980);
        finish_out(1, 0, 0, '0, 0);

        for (int n = 0; n < 4; n++) begin
            set_rand(1);
            do_start(W'($urandom), 1'($urandom));
            feed(60, N_TAPS, 0);
            finish_out(n, 0, 0, '0, 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/maclyr_seq.md
Name: maclyr_seq

Overview:
- Parametrised, time-multiplexed fixed-point MAC neuron. Successor to the fixed 9-tap combinational layer MAC.
- Accepts N_TAPS data/weight pairs serially over a valid/ready handshake, then adds a bias.
- Accumulates at full precision, rescales, and optionally saturates and applies ReLU.
- Presents one result per neuron on a valid/ready output. Sits between the weight/activation buffers and the layer output buffer of the VAE datapath.

Parameters:
- W, 16, data/weight/bias/result width (signed two's complement).
- FRAC, 8, fractional bits of the fixed-point format (Q(W-FRAC).FRAC).
- N_TAPS, 9, products per neuron (≥1).
- SAT, 1, 1 = saturate result to signed W range; 0 = wrap (keep low W bits).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin neuron; samples bias.
- bias  in  W  bias value, Q format, sampled with start.
- relu_en  in  1  sampled with start; 1 = clamp negative result to 0.
- in_valid  in  1  data/weight pair valid.
- in_ready  out  1  block accepts pair.
- in_data  in  W  activation.
- in_weight  in  W  weight.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  W  result.
- busy  out  1  state ≠ IDLE.
- tap_cnt  out  clog2(N_TAPS+1)  pairs accepted in current neuron.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: state = IDLE; in_ready, out_valid, busy = 0; out_data, tap_cnt and the accumulator = 0.
- Accumulator width: ACC_W = 2W + clog2(N_TAPS) + 2, signed.
- Product: full signed W×W = 2W bits, sign-extended to ACC_W. No per-product truncation.
- States: IDLE, ACC, OUT.
- IDLE:
  - in_ready = 0.
  - start = 1 → acc ← sign-extended bias <<< FRAC; tap_cnt ← 0; relu flag latched; next state ACC.
- ACC:
  - in_ready = 1.
  - Each cycle with in_valid & in_ready: acc ← acc + in_data × in_weight; tap_cnt++.
  - Cycles with in_valid = 0 hold all state; gaps are allowed.
  - When the accepted pair is tap N_TAPS-1, compute the final sum (acc + product) in the same cycle and register out_data from it. Next state OUT, out_valid = 1 on the following cycle. Latency: last pair accepted → out_valid = 1 cycle.
- Rescale:
  - r = final_acc >>> FRAC (arithmetic shift, truncation toward −inf).
  - SAT = 1: r > 2^(W-1)-1 → 2^(W-1)-1; r < −2^(W-1) → −2^(W-1).
  - SAT = 0: low W bits of r.
  - ReLU is applied after saturation/wrap: if the relu flag is set and the result is negative → 0.
- OUT:
  - out_valid = 1; in_ready = 0.
  - out_data is stable until handshake; out_valid does not drop without out_ready.
  - out_valid & out_ready → IDLE. If start = 1 in that same cycle → go directly to ACC with the new bias (back-to-back neurons, no bubble).
- start outside IDLE is ignored, except in the OUT handshake cycle.
- tap_cnt reads N_TAPS while in OUT; it resets to 0 on the next start.
- N_TAPS = 1: one pair accepted, then OUT.
- Reset asserted mid-operation: immediate return to reset values. The partial accumulation is discarded and no out_valid is produced.
- Inputs are not registered before use. The product and accumulate path is single-cycle; the synthesis target meets timing at W = 16.

Test Plan (W=16, FRAC=8, N_TAPS=9):
- Basic MAC:
  - Stimulus: start, bias = 0x0080, relu_en = 0; 9 pairs of 0x0100 × 0x0100, in_valid held high.
  - Response: out_valid 1 cycle after 9th accept; out_data = 0x0980; tap_cnt = 9.
- Negative/ReLU:
  - Stimulus: bias = 0, 9 pairs of 0xFF00 × 0x0200.
  - Response: relu_en = 0 → 0xEE00 (−18.0); repeat with relu_en = 1 → 0x0000.
- Saturation and wrap:
  - Stimulus: bias = 0, 9 pairs of 0x7FFF × 0x7FFF.
  - Response: SAT = 1 → 0x7FFF. SAT = 0 build → 0xF700 (full sum 0x23FF70009 >>> 8, low 16 bits). Same with 0x8000 × 0x7FFF, SAT = 1 → 0x8000.
- Handshake stress:
  - Stimulus: in_valid random 50%; out_ready low 5 cycles after out_valid rises.
  - Response: result matches model; out_data stable and in_ready = 0 while stalled; exactly one result per neuron. Start asserted in the handshake cycle → next neuron begins with no idle cycle.
- Reset mid-operation:
  - Stimulus: rst_n low asynchronously after 4 accepted pairs, then released; new neuron with the basic-MAC stimulus.
  - Response: all outputs 0 immediately, no out_valid for the aborted neuron; new result = 0x0980.
- Spurious start:
  - Stimulus: start pulsed during ACC and during OUT without out_ready.
  - Response: ignored; bias and tap_cnt unchanged; result unaffected.
